// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding, memory access type codes
// and the word-alignment helper.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Load/store type codes understood by the memory controller
  localparam logic [2:0] LS_LB = 3'b100;
  localparam logic [2:0] LS_LH = 3'b101;
  localparam logic [2:0] LS_LW = 3'b000;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// slave: the cache itself; master: the surrounding IFU + memory controller.
interface icache_if;
  logic        fetch_req_in;
  logic [31:0] fetch_addr_in;
  logic        flush_in;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  logic        mem_activate_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_r_nw_out;
  logic [2:0]  mem_type_out;
  logic [31:0] mem_data_in;
  logic        mem_data_available_in;
  logic        mem_block_in;
  logic        io_buffer_full_in;

  modport slave (
    input  fetch_req_in, fetch_addr_in, flush_in,
    input  mem_data_in, mem_data_available_in, mem_block_in, io_buffer_full_in,
    output inst_out, inst_valid_out,
    output mem_activate_out, mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out
  );

  modport master (
    output fetch_req_in, fetch_addr_in, flush_in,
    output mem_data_in, mem_data_available_in, mem_block_in, io_buffer_full_in,
    input  inst_out, inst_valid_out,
    input  mem_activate_out, mem_addr_out, mem_data_out, mem_r_nw_out, mem_type_out
  );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, one registered fill port.
// Only the valid bits are reset; tag/data contents are meaningless until valid is set.
module icache_array #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] i_rd_addr,
  output logic        o_hit,
  output logic [31:0] o_rd_data,
  input  logic        i_we,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [31:0]           r_data [LINES];

  logic [INDEX_BITS-1:0] w_rd_idx, w_wr_idx;
  logic [TAG_W-1:0]      w_rd_tag, w_wr_tag;
  logic                  w_unused;

  assign w_rd_idx  = i_rd_addr[INDEX_BITS+1:2];
  assign w_rd_tag  = i_rd_addr[31:INDEX_BITS+2];
  assign w_wr_idx  = i_wr_addr[INDEX_BITS+1:2];
  assign w_wr_tag  = i_wr_addr[31:INDEX_BITS+2];
  assign w_unused  = ^{i_rd_addr[1:0], i_wr_addr[1:0]};

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_data = r_data[w_rd_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)   r_valid           <= '0;
    else if (i_we) r_valid[w_wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache: 1-cycle hits, single-word refills that yield
// to load/store traffic on the shared memory controller port.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  icache_if.slave bus
);
  state_e      r_state, w_state_nxt;
  logic        r_act, w_act_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic        r_ivld, w_ivld_nxt;
  logic        r_drop, w_drop_nxt;
  logic        w_grant, w_hit, w_fill;
  logic [31:0] w_hit_data;

  icache_array #(.INDEX_BITS(INDEX_BITS)) u_arr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_rd_addr (bus.fetch_addr_in),
    .o_hit     (w_hit),
    .o_rd_data (w_hit_data),
    .i_we      (w_fill),
    .i_wr_addr (r_addr),
    .i_wr_data (bus.mem_data_in)
  );

  // The controller accepts our read in exactly this cycle
  assign w_grant = rdy_in & r_act & ~bus.mem_block_in & ~bus.io_buffer_full_in
                 & ~bus.mem_data_available_in;

  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    w_addr_nxt  = r_addr;
    w_inst_nxt  = r_inst;
    w_ivld_nxt  = 1'b0;
    w_drop_nxt  = r_drop;
    w_fill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.fetch_req_in && !bus.flush_in) begin
          if (w_hit) begin
            w_inst_nxt = w_hit_data;
            w_ivld_nxt = 1'b1;
          end else begin
            w_addr_nxt  = word_addr(bus.fetch_addr_in);
            w_act_nxt   = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A grant means the memory cycle is already committed, so it outranks a flush
        if (w_grant) begin
          w_act_nxt   = 1'b0;
          w_drop_nxt  = bus.flush_in;
          w_state_nxt = ST_WAIT;
        end else if (bus.flush_in) begin
          w_act_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.mem_data_available_in) begin
          w_fill = rdy_in;
          if (!r_drop && !bus.flush_in) begin
            w_inst_nxt = bus.mem_data_in;
            w_ivld_nxt = 1'b1;
          end
          w_drop_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (bus.flush_in) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: begin
        w_act_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_state <= ST_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_act  <= 1'b0;
      r_addr <= '0;
      r_inst <= '0;
      r_ivld <= 1'b0;
      r_drop <= 1'b0;
    end else if (rdy_in) begin
      r_act  <= w_act_nxt;
      r_addr <= w_addr_nxt;
      r_inst <= w_inst_nxt;
      r_ivld <= w_ivld_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign bus.inst_out         = r_inst;
  assign bus.inst_valid_out   = r_ivld;
  assign bus.mem_activate_out = r_act;
  assign bus.mem_addr_out     = r_addr;
  assign bus.mem_data_out     = '0;
  assign bus.mem_r_nw_out     = 1'b1;
  assign bus.mem_type_out     = LS_LW;
endmodule
